// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter
//   Shares one single-clock FIFO between two write requesters using round-robin
//   arbitration with bounded bursts, and drains that FIFO to one downstream
//   consumer over a valid/ready interface.
// Ports
//   clock, reset                 : system clock, synchronous active-high reset
//   req0_valid/data, req0_ready  : requester 0 write channel (ready = beat accepted)
//   req1_valid/data, req1_ready  : requester 1 write channel
//   fifo_write_en, fifo_data_in  : FIFO write side
//   fifo_full                    : FIFO full flag
//   fifo_read_en, fifo_empty     : FIFO read side
//   fifo_data_out                : FIFO read data, valid the cycle after fifo_read_en
//   out_valid, out_data          : registered output word to the consumer
//   out_ready                    : consumer accepts the word when out_valid && out_ready
//   grant                        : one-hot write owner (01 req0, 10 req1, 00 idle)
module fifo_access_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  fifo_write_en,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_full,
  output logic                  fifo_read_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            grant
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_G0, S_G1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_grant;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [CNT_W-1:0]      w_count_inc;
  logic                  r_last;      // 1 = req1 was served most recently
  logic                  w_last_nxt;
  logic                  w_own_valid;
  logic                  w_oth_valid;
  logic                  w_accept;
  logic                  r_inflight;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  w_read_en;

  // Write-side state register; grant is a registered decode of the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= 2'b00;
      r_count <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= {w_state_nxt == S_G1, w_state_nxt == S_G0};
      r_count <= w_count_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Write-side next state, beat acceptance and FIFO write mux
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_last_nxt    = r_last;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    fifo_write_en = 1'b0;
    fifo_data_in  = '0;
    w_own_valid   = 1'b0;
    w_oth_valid   = 1'b0;
    w_accept      = 1'b0;
    w_count_inc   = r_count + CNT_W'(1);

    case (r_state)
      S_IDLE: begin
        w_count_nxt = '0;
        if (req0_valid && req1_valid) begin
          w_state_nxt = r_last ? S_G0 : S_G1;
        end else if (req0_valid) begin
          w_state_nxt = S_G0;
        end else if (req1_valid) begin
          w_state_nxt = S_G1;
        end
      end
      S_G0, S_G1: begin
        if (r_state == S_G0) begin
          req0_ready   = !fifo_full;
          fifo_data_in = req0_data;
          w_own_valid  = req0_valid;
          w_oth_valid  = req1_valid;
        end else begin
          req1_ready   = !fifo_full;
          fifo_data_in = req1_data;
          w_own_valid  = req1_valid;
          w_oth_valid  = req0_valid;
        end
        w_accept      = w_own_valid && !fifo_full;
        fifo_write_en = w_accept;
        if (w_accept) begin
          w_count_nxt = w_count_inc;
          w_last_nxt  = (r_state == S_G1);
        end
        // A stalled (full) owner keeps grant and count; rotation only on a real release
        if (!w_own_valid || (w_accept && w_count_inc == CNT_W'(MAX_BURST))) begin
          w_count_nxt = '0;
          if (w_oth_valid) begin
            w_state_nxt = (r_state == S_G0) ? S_G1 : S_G0;
          end else if (w_own_valid) begin
            w_state_nxt = r_state;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase

    if (reset) begin
      req0_ready    = 1'b0;
      req1_ready    = 1'b0;
      fifo_write_en = 1'b0;
    end
  end

  // Read issue: one outstanding read at a time, only when the output slot frees up
  assign w_read_en = !reset && !fifo_empty && !r_inflight && (!r_out_valid || out_ready);

  // Read side: capture FIFO data one cycle after the read, hold until consumed
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_inflight <= w_read_en;
      if (r_inflight) begin
        r_out_data  <= fifo_data_out;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign fifo_read_en = w_read_en;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign grant        = r_grant;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Bench for fifo_access_arbiter with a small FIFO model attached to the FIFO ports.
module tb_fifo_access_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       fifo_write_en, fifo_read_en;
  logic [7:0] fifo_data_in;
  logic [7:0] fifo_data_out = 8'h00;
  logic       fifo_full, fifo_empty;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [1:0] grant;

  int n_checks = 0;
  int n_pass   = 0;

  // FIFO model state
  logic [7:0] mem  [0:15];
  logic [7:0] wlog [0:63];
  int wp = 0;
  int rp = 0;
  int depth = 16;
  int rd_empty_err = 0;

  always #5 clock = ~clock;

  fifo_access_arbiter #(.DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_full     (fifo_full),
    .fifo_read_en  (fifo_read_en),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .grant         (grant)
  );

  assign fifo_full  = ((wp - rp) >= depth);
  assign fifo_empty = (wp == rp);

  // FIFO model: registered read data, write log for ordering checks
  always @(posedge clock) begin
    if (reset) begin
      wp <= 0;
      rp <= 0;
    end else begin
      if (fifo_read_en) begin
        if (wp == rp) rd_empty_err <= rd_empty_err + 1;
        fifo_data_out <= mem[rp[3:0]];
        rp <= rp + 1;
      end
      if (fifo_write_en) begin
        mem[wp[3:0]]  <= fifo_data_in;
        wlog[wp[5:0]] <= fifo_data_in;
        wp <= wp + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b;
    int n, got, cyc, last_cyc;

    // Reset state, with a requester already waiting
    reset = 1'b1; req1_valid = 1'b0; req1_data = 8'h00; out_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h04;
    tick();
    tick();
    check("rst_grant",     32'(grant), 32'd0);
    check("rst_ready0",    32'(req0_ready), 32'd0);
    check("rst_we",        32'(fifo_write_en), 32'd0);
    check("rst_re",        32'(fifo_read_en), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data), 32'd0);

    // Test 1: single requester, full burst then restart, then idle
    reset = 1'b0;
    #1;
    check("t1_idle_ready", 32'(req0_ready), 32'd0);
    check("t1_idle_we",    32'(fifo_write_en), 32'd0);
    tick();
    check("t1_grant", 32'(grant), 32'd1);
    for (int k = 0; k < 4; k++) begin
      req0_data = 8'(4 + k);
      #1;
      check("t1_we",  32'(fifo_write_en), 32'd1);
      check("t1_din", 32'(fifo_data_in), 32'(4 + k));
      tick();
    end
    check("t1_restart_grant", 32'(grant), 32'd1);
    req0_valid = 1'b0;
    #1;
    check("t1_we_off", 32'(fifo_write_en), 32'd0);
    tick();
    check("t1_idle_grant", 32'(grant), 32'd0);
    check("t1_idle_din",   32'(fifo_data_in), 32'd0);
    check("t1_wlog", 32'({wlog[0], wlog[1], wlog[2], wlog[3]}), 32'h04050607);

    // Test 5: consumer stalled holds one word, exactly one read issued
    check("t5_reads",     32'(rp), 32'd1);
    check("t5_out_valid", 32'(out_valid), 32'd1);
    check("t5_out_data",  32'(out_data), 32'h04);
    check("t5_re_hold",   32'(fifo_read_en), 32'd0);
    tick(); tick(); tick();
    check("t5_stable",    32'(out_data), 32'h04);
    check("t5_reads2",    32'(rp), 32'd1);
    out_ready = 1'b1;
    #1;
    check("t5_re_release", 32'(fifo_read_en), 32'd1);
    tick();
    out_ready = 1'b0;
    check("t5_consumed",  32'(out_valid), 32'd0);
    check("t5_re_inflight", 32'(fifo_read_en), 32'd0);
    tick();
    check("t5_next_valid", 32'(out_valid), 32'd1);
    check("t5_next_data",  32'(out_data), 32'h05);
    check("t5_reads3",     32'(rp), 32'd2);

    // Test 2: both requesters continuously valid, 4-beat rotation starting with req0
    do_reset();
    depth = 16;
    req0_valid = 1'b1; req0_data = 8'hA0;
    req1_valid = 1'b1; req1_data = 8'hB0;
    #1;
    check("t2_idle_we", 32'(fifo_write_en), 32'd0);
    tick();
    for (int k = 0; k < 16; k++) begin
      check("t2_grant", 32'(grant), ((k / 4) % 2 == 0) ? 32'd1 : 32'd2);
      check("t2_din",   32'(fifo_data_in), ((k / 4) % 2 == 0) ? 32'hA0 : 32'hB0);
      check("t2_we",    32'(fifo_write_en), 32'd1);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t2_wlog_a", 32'({wlog[0], wlog[3], wlog[4], wlog[7]}), 32'hA0A0B0B0);
    check("t2_wlog_b", 32'({wlog[8], wlog[11], wlog[12], wlog[15]}), 32'hA0A0B0B0);
    check("t2_wcount", 32'(wp), 32'd16);

    // Test 3: FIFO full stalls the owner without rotation; count resumes after reads
    do_reset();
    depth = 4;
    req0_valid = 1'b1; req0_data = 8'h30;
    n = 0;
    while (!fifo_full && n < 20) begin
      tick();
      n++;
    end
    check("t3_full_seen", 32'(fifo_full), 32'd1);
    check("t3_writes",    32'(wp), 32'd5);
    check("t3_ready0",    32'(req0_ready), 32'd0);
    check("t3_we",        32'(fifo_write_en), 32'd0);
    req1_valid = 1'b1; req1_data = 8'h41;
    tick();
    check("t3_grant_hold", 32'(grant), 32'd1);
    check("t3_ready1",     32'(req1_ready), 32'd0);
    check("t3_we_hold",    32'(fifo_write_en), 32'd0);
    for (int r = 0; r < 3; r++) begin
      out_ready = 1'b1;
      #1;
      check("t3_re", 32'(fifo_read_en), 32'd1);
      tick();
      out_ready = 1'b0;
      check("t3_resume_ready", 32'(req0_ready), 32'd1);
      check("t3_resume_we",    32'(fifo_write_en), 32'd1);
      tick();
      check("t3_grant_after", 32'(grant), (r == 2) ? 32'd2 : 32'd1);
      check("t3_full_again",  32'(fifo_full), 32'd1);
    end
    check("t3_g1_stalled", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Test 4: drain 04,03,02,01 at one word per two cycles
    do_reset();
    depth = 16;
    req0_valid = 1'b1;
    tick();
    for (int d = 4; d >= 1; d--) begin
      req0_data = 8'(d);
      tick();
    end
    req0_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("t4_first", 32'(out_data), 32'h04);
    out_ready = 1'b1;
    got = 0; cyc = 0; last_cyc = 0;
    while (got < 4 && cyc < 20) begin
      if (out_valid) begin
        exp_b = 8'(4 - got);
        check("t4_data", 32'(out_data), 32'(exp_b));
        if (got > 0) check("t4_gap", 32'(cyc - last_cyc), 32'd2);
        last_cyc = cyc;
        got++;
      end
      tick();
      cyc++;
    end
    check("t4_count", 32'(got), 32'd4);
    tick(); tick();
    check("t4_drained_re", 32'(fifo_read_en), 32'd0);
    check("t4_drained_ov", 32'(out_valid), 32'd0);
    check("rd_when_empty", 32'(rd_empty_err), 32'd0);
    out_ready = 1'b0;

    // Test 6: reset mid-burst with a read in flight
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h60;
    tick();
    tick();
    tick();
    check("t6_midburst_we", 32'(fifo_write_en), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_rst_ready0", 32'(req0_ready), 32'd0);
    check("t6_rst_we",     32'(fifo_write_en), 32'd0);
    check("t6_rst_re",     32'(fifo_read_en), 32'd0);
    tick();
    check("t6_grant",     32'(grant), 32'd0);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_out_data",  32'(out_data), 32'd0);
    check("t6_we",        32'(fifo_write_en), 32'd0);
    check("t6_re",        32'(fifo_read_en), 32'd0);
    req0_valid = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    check("t6_discarded", 32'(out_valid), 32'd0);
    check("t6_idle",      32'(grant), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
